cache_axi_bridge: RTL and testbench

- Responder for the cache refill/writeback request interface (rd_req/rd_rdy/ret_*, wr_req/wr_rdy).
- Converts each accepted request into an AXI4 master transaction: a 4-beat INCR burst for a cache line, or a single beat for uncached access.
- Sits between the I/D caches and the SoC AXI interconnect.
- At most one outstanding read and one outstanding write.

---
 rtl/cache_axi_bridge.sv | 198 +++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// Cache refill/writeback port to AXI4 master bridge.
// One outstanding read and one outstanding write; line = 4-beat INCR burst.
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_strb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

  r_state_e       r_state_q, r_state_d;
  logic [31:0]    rd_addr_q, rd_addr_d;
  logic [2:0]     rd_type_q, rd_type_d;

  w_state_e       w_state_q, w_state_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [2:0]     wr_type_q, wr_type_d;
  logic [3:0]     wr_strb_q, wr_strb_d;
  logic [127:0]   wr_data_q, wr_data_d;
  logic [1:0]     beat_cnt_q, beat_cnt_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;

  logic           rd_hit_busy;
  logic           rd_hit_new;
  logic           unused_resp;

  assign unused_resp = ^{rresp, bresp};

  // A read may not overtake a pending or same-cycle write to its line
  assign wr_rdy      = (w_state_q == W_IDLE);
  assign rd_hit_busy = (w_state_q != W_IDLE) &&
                       (rd_addr[31:4] == wr_addr_q[31:4]);
  assign rd_hit_new  = wr_req && wr_rdy &&
                       (rd_addr[31:4] == wr_addr[31:4]);
  assign rd_rdy      = (r_state_q == R_IDLE) &&
                       !rd_hit_busy && !rd_hit_new;

  assign arid    = RD_ID;
  assign araddr  = rd_addr_q;
  assign arlen   = rd_type_q[2] ? 8'd3 : 8'd0;
  assign arsize  = rd_type_q[2] ? 3'b010 : {1'b0, rd_type_q[1:0]};
  assign arburst = 2'b01;
  assign arvalid = (r_state_q == R_AR);

  assign rready    = (r_state_q == R_DATA);
  assign ret_valid = rready && rvalid;
  assign ret_last  = rready && rlast;
  assign ret_data  = rdata;

  assign awid    = WR_ID;
  assign awaddr  = wr_addr_q;
  assign awlen   = wr_type_q[2] ? 8'd3 : 8'd0;
  assign awsize  = wr_type_q[2] ? 3'b010 : {1'b0, wr_type_q[1:0]};
  assign awburst = 2'b01;
  assign awvalid = (w_state_q == W_REQ) && !aw_done_q;

  assign wdata  = wr_type_q[2] ? wr_data_q[{beat_cnt_q, 5'd0} +: 32]
                               : wr_data_q[31:0];
  assign wstrb  = wr_type_q[2] ? 4'b1111 : wr_strb_q;
  assign wlast  = wr_type_q[2] ? (beat_cnt_q == 2'd3) : 1'b1;
  assign wvalid = (w_state_q == W_REQ) && !w_done_q;
  assign bready = (w_state_q == W_RESP);

  // Read sequencing: accept, issue AR, stream R beats back
  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    rd_type_d = rd_type_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (rd_req && rd_rdy) begin
          rd_addr_d = rd_addr;
          rd_type_d = rd_type;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid && rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write sequencing: AW and W channels progress independently
  always_comb begin
    w_state_d  = w_state_q;
    wr_addr_d  = wr_addr_q;
    wr_type_d  = wr_type_q;
    wr_strb_d  = wr_strb_q;
    wr_data_d  = wr_data_q;
    beat_cnt_d = beat_cnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_req) begin
          wr_addr_d  = wr_addr;
          wr_type_d  = wr_type;
          wr_strb_d  = wr_strb;
          wr_data_d  = wr_data;
          beat_cnt_d = 2'd0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          w_state_d  = W_REQ;
        end
      end
      W_REQ: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (wlast) w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // State and latched payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q  <= R_IDLE;
      rd_addr_q  <= '0;
      rd_type_q  <= '0;
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      wr_type_q  <= '0;
      wr_strb_q  <= '0;
      wr_data_q  <= '0;
      beat_cnt_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_type_q  <= rd_type_d;
      w_state_q  <= w_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_type_q  <= wr_type_d;
      wr_strb_q  <= wr_strb_d;
      wr_data_q  <= wr_data_d;
      beat_cnt_q <= beat_cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Bench for cache_axi_bridge: directed scenarios, then random traffic
// against a transaction-level model of the request and AXI channels.
module tb_cache_axi_bridge;

  logic         clk;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_strb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_strb(wr_strb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit auto_slave = 1'b0;
  bit rd_acc = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of what the bridge owes each channel
  bit          m_rd_out, m_ar_done;
  logic [31:0] m_rd_addr;
  logic [2:0]  m_rd_type;
  bit          m_wr_out, m_aw_done;
  int          m_wbeats;
  logic [31:0] m_wr_addr;
  logic [2:0]  m_wr_type;
  logic [3:0]  m_wr_strb;
  logic [127:0] m_wr_data;

  function automatic logic [2:0] size_of(input logic [2:0] t);
    return t[2] ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  // Compare process: checks every output each cycle, then advances model
  always @(negedge clk) begin
    int nb;
    bit e_rdy, e_ar, e_r, e_aw, e_w, e_b;
    if (mon_en) begin
      nb = m_wr_type[2] ? 4 : 1;
      e_rdy = !m_rd_out
            && !(m_wr_out && rd_addr[31:4] == m_wr_addr[31:4])
            && !(wr_req && !m_wr_out && rd_addr[31:4] == wr_addr[31:4]);
      e_ar = m_rd_out && !m_ar_done;
      e_r  = m_rd_out && m_ar_done;
      e_aw = m_wr_out && !m_aw_done;
      e_w  = m_wr_out && (m_wbeats < nb);
      e_b  = m_wr_out && m_aw_done && (m_wbeats == nb);
      cmp("rd_rdy", {31'd0, rd_rdy}, {31'd0, e_rdy});
      cmp("wr_rdy", {31'd0, wr_rdy}, {31'd0, !m_wr_out});
      cmp("arvalid", {31'd0, arvalid}, {31'd0, e_ar});
      if (e_ar) begin
        cmp("araddr", araddr, m_rd_addr);
        cmp("arlen", {24'd0, arlen}, m_rd_type[2] ? 32'd3 : 32'd0);
        cmp("arsize", {29'd0, arsize}, {29'd0, size_of(m_rd_type)});
        cmp("arburst", {30'd0, arburst}, 32'd1);
        cmp("arid", {28'd0, arid}, 32'd0);
      end
      cmp("rready", {31'd0, rready}, {31'd0, e_r});
      cmp("ret_valid", {31'd0, ret_valid}, {31'd0, e_r && rvalid});
      if (e_r && rvalid) begin
        cmp("ret_data", ret_data, rdata);
        cmp("ret_last", {31'd0, ret_last}, {31'd0, rlast});
      end
      cmp("awvalid", {31'd0, awvalid}, {31'd0, e_aw});
      if (e_aw) begin
        cmp("awaddr", awaddr, m_wr_addr);
        cmp("awlen", {24'd0, awlen}, m_wr_type[2] ? 32'd3 : 32'd0);
        cmp("awsize", {29'd0, awsize}, {29'd0, size_of(m_wr_type)});
        cmp("awburst", {30'd0, awburst}, 32'd1);
        cmp("awid", {28'd0, awid}, 32'd1);
      end
      cmp("wvalid", {31'd0, wvalid}, {31'd0, e_w});
      if (e_w) begin
        cmp("wdata", wdata, m_wr_type[2] ? m_wr_data[m_wbeats*32 +: 32]
                                         : m_wr_data[31:0]);
        cmp("wstrb", {28'd0, wstrb},
            m_wr_type[2] ? 32'hF : {28'd0, m_wr_strb});
        cmp("wlast", {31'd0, wlast}, {31'd0, m_wbeats == nb - 1});
      end
      cmp("bready", {31'd0, bready}, {31'd0, e_b});
    end
    rd_acc = rd_req && rd_rdy;
    if (reset) begin
      m_rd_out = 0; m_ar_done = 0; m_rd_addr = '0; m_rd_type = '0;
      m_wr_out = 0; m_aw_done = 0; m_wbeats = 0;
      m_wr_addr = '0; m_wr_type = '0; m_wr_strb = '0; m_wr_data = '0;
    end else begin
      if (arvalid && arready) m_ar_done = 1;
      if (rready && rvalid && rlast) m_rd_out = 0;
      if (rd_req && rd_rdy) begin
        m_rd_out = 1; m_ar_done = 0;
        m_rd_addr = rd_addr; m_rd_type = rd_type;
      end
      if (awvalid && awready) m_aw_done = 1;
      if (wvalid && wready) m_wbeats++;
      if (bvalid && bready) m_wr_out = 0;
      if (wr_req && wr_rdy) begin
        m_wr_out = 1; m_aw_done = 0; m_wbeats = 0;
        m_wr_addr = wr_addr; m_wr_type = wr_type;
        m_wr_strb = wr_strb; m_wr_data = wr_data;
      end
    end
  end

  // Random AXI slave used in the random phase
  int s_rd_left = 0;
  bit s_aw = 0, s_w = 0;
  always begin
    @(negedge clk);
    if (reset) begin
      s_rd_left = 0; s_aw = 0; s_w = 0;
    end else if (auto_slave) begin
      if (arvalid && arready) s_rd_left = int'(arlen) + 1;
      else if (rvalid && rready) s_rd_left--;
      if (awvalid && awready) s_aw = 1;
      if (wvalid && wready && wlast) s_w = 1;
      if (bvalid && bready) begin s_aw = 0; s_w = 0; end
    end
    @(posedge clk);
    #1;
    if (auto_slave) begin
      arready = 1'($urandom_range(0, 1));
      rvalid  = (s_rd_left > 0) && ($urandom_range(0, 2) != 0);
      rdata   = $urandom;
      rlast   = (s_rd_left == 1);
      rresp   = 2'($urandom);
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = s_aw && s_w && (bvalid || $urandom_range(0, 2) == 0);
      bresp   = 2'($urandom);
    end
  end

  function automatic logic [2:0] rnd_type();
    int t;
    t = $urandom_range(0, 3);
    return (t == 3) ? 3'b100 : 3'(t);
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'h8000_0000 | (32'($urandom_range(0, 3)) << 4)
         | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    int got;
    logic [4:0] wpat;
    reset = 1; rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_strb = 0; wr_data = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    tick;
    mon_en = 1;
    tick;
    reset = 0;

    // Reset state
    @(negedge clk);
    cmp("rst_arvalid", {31'd0, arvalid}, 32'd0);
    cmp("rst_awvalid", {31'd0, awvalid}, 32'd0);
    cmp("rst_wvalid", {31'd0, wvalid}, 32'd0);
    cmp("rst_bready", {31'd0, bready}, 32'd0);
    cmp("rst_rready", {31'd0, rready}, 32'd0);
    cmp("rst_rd_rdy", {31'd0, rd_rdy}, 32'd1);
    cmp("rst_wr_rdy", {31'd0, wr_rdy}, 32'd1);

    // Line read with arready after 2 cycles
    tick;
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h1C00_0040;
    @(negedge clk);
    cmp("lr_accept", {31'd0, rd_rdy}, 32'd1);
    tick;
    rd_req = 0;
    @(negedge clk);
    cmp("lr_arvalid", {31'd0, arvalid}, 32'd1);
    cmp("lr_araddr", araddr, 32'h1C00_0040);
    cmp("lr_arlen", {24'd0, arlen}, 32'd3);
    cmp("lr_arsize", {29'd0, arsize}, 32'd2);
    tick;
    tick;
    arready = 1;
    @(negedge clk);
    cmp("lr_ar_held", araddr, 32'h1C00_0040);
    tick;
    arready = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'hA0A0_0000 + 32'(i); rlast = (i == 3);
      @(negedge clk);
      cmp("lr_ret_valid", {31'd0, ret_valid}, 32'd1);
      cmp("lr_ret_data", ret_data, 32'hA0A0_0000 + 32'(i));
      cmp("lr_ret_last", {31'd0, ret_last}, (i == 3) ? 32'd1 : 32'd0);
      tick;
    end
    rvalid = 0; rlast = 0;
    @(negedge clk);
    cmp("lr_rdy_after", {31'd0, rd_rdy}, 32'd1);

    // Line write with wready 1,0,1,1,1
    tick;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h80; wr_strb = 4'b0;
    wr_data = 128'h33333333_22222222_11111111_00000000;
    awready = 1;
    tick;
    wr_req = 0;
    got = 0;
    wpat = 5'b11101;
    for (int k = 0; k < 5; k++) begin
      wready = wpat[k];
      @(negedge clk);
      cmp("lw_wr_rdy", {31'd0, wr_rdy}, 32'd0);
      if (wvalid && wready) begin
        cmp("lw_wdata", wdata, 32'(32'h1111_1111 * got));
        cmp("lw_wlast", {31'd0, wlast}, (got == 3) ? 32'd1 : 32'd0);
        got++;
      end
      tick;
    end
    wready = 0; awready = 0;
    cmp("lw_beats", 32'(got), 32'd4);
    @(negedge clk);
    cmp("lw_bready", {31'd0, bready}, 32'd1);
    tick;
    bvalid = 1;
    @(negedge clk);
    cmp("lw_wr_rdy_b", {31'd0, wr_rdy}, 32'd0);
    tick;
    bvalid = 0;
    @(negedge clk);
    cmp("lw_wr_rdy_done", {31'd0, wr_rdy}, 32'd1);

    // Single half write; AW accepted only after W is done
    tick;
    wr_req = 1; wr_type = 3'b001; wr_addr = 32'h1FAF_0002;
    wr_strb = 4'b1100; wr_data = 128'h1234_DEAD_BEEF;
    tick;
    wr_req = 0; wready = 1; awready = 0;
    @(negedge clk);
    cmp("sw_awlen", {24'd0, awlen}, 32'd0);
    cmp("sw_awsize", {29'd0, awsize}, 32'd1);
    cmp("sw_wstrb", {28'd0, wstrb}, 32'hC);
    cmp("sw_wlast", {31'd0, wlast}, 32'd1);
    cmp("sw_wdata", wdata, 32'hDEAD_BEEF);
    tick;
    wready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("aw_late_bready", {31'd0, bready}, 32'd0);
      cmp("aw_late_awaddr", awaddr, 32'h1FAF_0002);
      if (i == 2) awready = 1;
      tick;
    end
    awready = 0;
    @(negedge clk);
    cmp("aw_late_bready_on", {31'd0, bready}, 32'd1);
    bvalid = 1;
    tick;
    bvalid = 0;

    // RAW hazard: write to 0x100, reads to 0x200 then 0x10C
    tick;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h100;
    wr_data = {$urandom, $urandom, $urandom, $urandom};
    rd_req = 1; rd_type = 3'b010; rd_addr = 32'h200;
    awready = 1; wready = 1; arready = 1;
    @(negedge clk);
    cmp("raw_other_line", {31'd0, rd_rdy}, 32'd1);
    tick;
    wr_req = 0; rd_req = 0;
    tick;
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h5555_5555;
    tick;
    rvalid = 0; rlast = 0; awready = 0;
    rd_req = 1; rd_addr = 32'h10C;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cmp("raw_blocked", {31'd0, rd_rdy}, 32'd0);
      tick;
    end
    wready = 0;
    bvalid = 1;
    @(negedge clk);
    cmp("raw_b_cycle", {31'd0, rd_rdy}, 32'd0);
    tick;
    bvalid = 0;
    @(negedge clk);
    cmp("raw_released", {31'd0, rd_rdy}, 32'd1);
    tick;
    rd_req = 0; arready = 1;
    @(negedge clk);
    cmp("raw_araddr", araddr, 32'h10C);
    tick;
    arready = 0; rvalid = 1; rlast = 1;
    tick;
    rvalid = 0; rlast = 0;

    // Reset in the middle of a line read
    tick;
    rd_req = 1; rd_type = 3'b100; rd_addr = 32'h3000; arready = 1;
    tick;
    rd_req = 0;
    tick;
    arready = 0; rvalid = 1; rdata = 32'h1;
    tick;
    rdata = 32'h2;
    tick;
    rvalid = 0; reset = 1;
    @(negedge clk);
    cmp("rr_in_data", {31'd0, rready}, 32'd1);
    tick;
    reset = 0; rvalid = 1; rdata = 32'h3;
    @(negedge clk);
    cmp("rr_arvalid", {31'd0, arvalid}, 32'd0);
    cmp("rr_rready", {31'd0, rready}, 32'd0);
    cmp("rr_ret_valid", {31'd0, ret_valid}, 32'd0);
    cmp("rr_rd_rdy", {31'd0, rd_rdy}, 32'd1);
    tick;
    rvalid = 0;

    // Random traffic against the model
    reset = 1;
    tick;
    reset = 0;
    auto_slave = 1;
    for (int c = 0; c < 4000; c++) begin
      tick;
      reset = ($urandom_range(0, 599) == 0);
      if (rd_req && rd_acc) rd_req = 0;
      if (!rd_req && $urandom_range(0, 3) == 0) begin
        rd_req = 1; rd_type = rnd_type(); rd_addr = rnd_addr();
      end
      wr_req = 0;
      if (wr_rdy && $urandom_range(0, 2) == 0) begin
        wr_req = 1; wr_type = rnd_type(); wr_addr = rnd_addr();
        wr_strb = 4'($urandom);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    tick;
    reset = 0; rd_req = 0; wr_req = 0;
    repeat (60) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
